// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-ported memory between the MEM-stage (port 0)
// and IF-stage (port 1) requesters, with an optional watchdog for unanswered transactions.
module mem_port_arbiter #(
    parameter int BITSIZE = 32,
    parameter int TIMEOUT = 0
) (
    input  logic               clk,
    input  logic               resetn_i,
    input  logic [BITSIZE-1:0] req0_addr_i,
    input  logic [BITSIZE-1:0] req0_data_i,
    input  logic               req0_read_i,
    input  logic               req0_write_i,
    output logic [BITSIZE-1:0] req0_data_o,
    output logic               req0_valid_o,
    input  logic [BITSIZE-1:0] req1_addr_i,
    input  logic [BITSIZE-1:0] req1_data_i,
    input  logic               req1_read_i,
    input  logic               req1_write_i,
    output logic [BITSIZE-1:0] req1_data_o,
    output logic               req1_valid_o,
    output logic [BITSIZE-1:0] mem_addr_o,
    output logic [BITSIZE-1:0] mem_data_o,
    output logic               mem_read_o,
    output logic               mem_write_o,
    input  logic [BITSIZE-1:0] mem_data_i,
    input  logic               mem_valid_i,
    output logic               busy_o,
    output logic               timeout_o
);
    typedef enum logic {IDLE, BUSY} state_t;

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    state_t             state, state_nxt;
    logic               gnt, gnt_nxt, last, last_nxt, pick;
    logic [CW-1:0]      cnt, cnt_nxt;
    logic [BITSIZE-1:0] addr_nxt, data_nxt;
    logic               rd_nxt, wr_nxt;
    logic               req0, req1, abort, done;

    assign req0 = req0_read_i | req0_write_i;
    assign req1 = req1_read_i | req1_write_i;

    // Abort fires on the cycle the counter would reach TIMEOUT; a same-cycle answer wins.
    assign abort = (TIMEOUT > 0) && (state == BUSY) && !mem_valid_i && (cnt == CNT_LAST);
    assign done  = (state == BUSY) && (mem_valid_i || abort);

    always_ff @(posedge clk or negedge resetn_i) begin
        if (!resetn_i) begin
            state       <= IDLE;
            gnt         <= 1'b0;
            last        <= 1'b1;
            cnt         <= '0;
            mem_addr_o  <= '0;
            mem_data_o  <= '0;
            mem_read_o  <= 1'b0;
            mem_write_o <= 1'b0;
        end else begin
            state       <= state_nxt;
            gnt         <= gnt_nxt;
            last        <= last_nxt;
            cnt         <= cnt_nxt;
            mem_addr_o  <= addr_nxt;
            mem_data_o  <= data_nxt;
            mem_read_o  <= rd_nxt;
            mem_write_o <= wr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        last_nxt  = last;
        cnt_nxt   = cnt;
        addr_nxt  = mem_addr_o;
        data_nxt  = mem_data_o;
        rd_nxt    = mem_read_o;
        wr_nxt    = mem_write_o;
        pick      = 1'b0;
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    // On a tie the port that did not win last time goes next.
                    pick      = (req0 && req1) ? ~last : req1;
                    gnt_nxt   = pick;
                    last_nxt  = pick;
                    state_nxt = BUSY;
                    addr_nxt  = pick ? req1_addr_i : req0_addr_i;
                    data_nxt  = pick ? req1_data_i : req0_data_i;
                    wr_nxt    = pick ? req1_write_i : req0_write_i;
                    rd_nxt    = pick ? (req1_read_i & ~req1_write_i)
                                     : (req0_read_i & ~req0_write_i);
                end
            end
            BUSY: begin
                if (done) begin
                    state_nxt = IDLE;
                    rd_nxt    = 1'b0;
                    wr_nxt    = 1'b0;
                    cnt_nxt   = '0;
                end else if (TIMEOUT > 0) begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign req0_valid_o = done && !gnt;
    assign req1_valid_o = done && gnt;
    // An aborted transaction returns zero data since mem_valid_i is low.
    assign req0_data_o  = (req0_valid_o && mem_valid_i) ? mem_data_i : '0;
    assign req1_data_o  = (req1_valid_o && mem_valid_i) ? mem_data_i : '0;
    assign busy_o       = (state == BUSY);
    assign timeout_o    = abort;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench for mem_port_arbiter (TIMEOUT=4): a transaction-level model
// predicts grants and completions, a negedge monitor compares whatever the DUT presents.
module tb_mem_port_arbiter;
    localparam int W  = 32;
    localparam int TO = 4;

    typedef struct packed { logic [W-1:0] addr; logic [W-1:0] data; logic rd; logic wr; } gnt_t;
    typedef struct packed { logic port; logic [W-1:0] data; logic to; } cpl_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         resetn_i;
    logic [W-1:0] req0_addr_i, req0_data_i, req1_addr_i, req1_data_i;
    logic         req0_read_i, req0_write_i, req1_read_i, req1_write_i;
    logic [W-1:0] req0_data_o, req1_data_o, mem_addr_o, mem_data_o, mem_data_i;
    logic         req0_valid_o, req1_valid_o, mem_read_o, mem_write_o, mem_valid_i;
    logic         busy_o, timeout_o;

    mem_port_arbiter #(.BITSIZE(W), .TIMEOUT(TO)) dut (
        .clk(clk), .resetn_i(resetn_i),
        .req0_addr_i(req0_addr_i), .req0_data_i(req0_data_i),
        .req0_read_i(req0_read_i), .req0_write_i(req0_write_i),
        .req0_data_o(req0_data_o), .req0_valid_o(req0_valid_o),
        .req1_addr_i(req1_addr_i), .req1_data_i(req1_data_i),
        .req1_read_i(req1_read_i), .req1_write_i(req1_write_i),
        .req1_data_o(req1_data_o), .req1_valid_o(req1_valid_o),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
        .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
        .mem_data_i(mem_data_i), .mem_valid_i(mem_valid_i),
        .busy_o(busy_o), .timeout_o(timeout_o)
    );

    int n_chk = 0, n_fail = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Requester and memory model state
    bit           p_pend[2], p_cool[2], p_rd[2], p_wr[2];
    logic [W-1:0] p_addr[2], p_data[2];
    bit           m_busy, m_last, m_port, cur_busy;
    int           m_age, m_lat, force_lat = -1;
    bit           use_force_data;
    logic [W-1:0] force_data;
    gnt_t         m_g, mon_g;
    gnt_t         g_q[$];
    cpl_t         c_q[$];

    task automatic issue(input int p, input logic [W-1:0] a, input logic [W-1:0] d,
                         input bit rd, input bit wr);
        p_pend[p] = 1; p_addr[p] = a; p_data[p] = d; p_rd[p] = rd; p_wr[p] = wr;
    endtask

    task automatic issue_rand(input int p);
        int k;
        k = $urandom_range(2);
        issue(p, $urandom, $urandom, k != 1, k != 0);
    endtask

    task automatic drive_reqs();
        req0_addr_i  = p_pend[0] ? p_addr[0] : '0;
        req0_data_i  = p_pend[0] ? p_data[0] : '0;
        req0_read_i  = p_pend[0] && p_rd[0];
        req0_write_i = p_pend[0] && p_wr[0];
        req1_addr_i  = p_pend[1] ? p_addr[1] : '0;
        req1_data_i  = p_pend[1] ? p_data[1] : '0;
        req1_read_i  = p_pend[1] && p_rd[1];
        req1_write_i = p_pend[1] && p_wr[1];
        // Mid-transaction the granted requester's inputs must not matter.
        if (m_busy && m_age >= 2 && $urandom_range(2) == 0) begin
            if (m_port == 0) begin
                req0_addr_i = $urandom; req0_data_i = $urandom;
                req0_read_i = 1'($urandom); req0_write_i = 1'($urandom);
            end else begin
                req1_addr_i = $urandom; req1_data_i = $urandom;
                req1_read_i = 1'($urandom); req1_write_i = 1'($urandom);
            end
        end
    endtask

    task automatic complete();
        p_pend[m_port] = 0;
        p_cool[m_port] = 1;
        m_busy = 0;
        use_force_data = 0;
    endtask

    task automatic step();
        logic [W-1:0] d;
        bit w;
        @(posedge clk); #1;
        p_cool[0] = 0; p_cool[1] = 0;
        mem_valid_i = 1'b0;
        mem_data_i  = $urandom;
        cur_busy    = m_busy;
        drive_reqs();
        if (m_busy) begin
            if (m_age == 1) g_q.push_back(m_g);
            if (m_age == m_lat) begin
                d = use_force_data ? force_data : W'($urandom);
                mem_valid_i = 1'b1;
                mem_data_i  = d;
                c_q.push_back('{port: m_port, data: d, to: 1'b0});
                complete();
            end else if (m_age == TO) begin
                c_q.push_back('{port: m_port, data: '0, to: 1'b1});
                complete();
            end else begin
                m_age++;
            end
        end else begin
            if ($urandom_range(5) == 0) mem_valid_i = 1'b1;
            if (p_pend[0] || p_pend[1]) begin
                w = (p_pend[0] && p_pend[1]) ? !m_last : p_pend[1];
                m_g = '{addr: p_addr[w], data: p_data[w], rd: p_rd[w] && !p_wr[w], wr: p_wr[w]};
                m_port = w; m_last = w; m_busy = 1; m_age = 1;
                m_lat = (force_lat >= 0) ? force_lat : $urandom_range(1, 6);
                force_lat = -1;
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mem_addr"}, mem_addr_o, '0);
        check({tag, "_mem_data"}, mem_data_o, '0);
        check({tag, "_req_data"}, req0_data_o | req1_data_o, '0);
        check({tag, "_flags"}, {mem_read_o, mem_write_o, req0_valid_o, req1_valid_o,
                                busy_o, timeout_o}, '0);
    endtask

    task automatic do_reset();
        resetn_i = 1'b0;
        #1 check_all_zero("reset_async");
        p_pend[0] = 0; p_pend[1] = 0; p_cool[0] = 0; p_cool[1] = 0;
        m_busy = 0; m_last = 1; cur_busy = 0; force_lat = -1; use_force_data = 0;
        g_q.delete(); c_q.delete();
        req0_addr_i = '0; req0_data_i = '0; req0_read_i = 0; req0_write_i = 0;
        req1_addr_i = '0; req1_data_i = '0; req1_read_i = 0; req1_write_i = 0;
        mem_valid_i = 0; mem_data_i = '0;
        repeat (3) @(posedge clk);
        #1 resetn_i = 1'b1;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && (m_busy || p_pend[0] || p_pend[1]); i++) step();
        check("drain_bound", 32'(m_busy || p_pend[0] || p_pend[1]), '0);
    endtask

    // Monitor: pops expectations whenever the model says the DUT should present something.
    always @(negedge clk) begin
        cpl_t c;
        if (!resetn_i) begin
            check_all_zero("in_reset");
        end else begin
            check("busy", 32'(busy_o), 32'(cur_busy));
            if (g_q.size() > 0) mon_g = g_q.pop_front();
            if (cur_busy) begin
                check("mem_addr", mem_addr_o, mon_g.addr);
                check("mem_data", mem_data_o, mon_g.data);
                check("mem_strobes", {mem_read_o, mem_write_o}, {mon_g.rd, mon_g.wr});
            end else begin
                check("idle_strobes", {mem_read_o, mem_write_o}, '0);
            end
            if (c_q.size() > 0) begin
                c = c_q.pop_front();
                check("valids", {req0_valid_o, req1_valid_o}, {!c.port, c.port});
                check("cpl_data", c.port ? req1_data_o : req0_data_o, c.data);
                check("other_data", c.port ? req0_data_o : req1_data_o, '0);
                check("timeout", 32'(timeout_o), 32'(c.to));
            end else begin
                check("no_cpl", {req0_valid_o, req1_valid_o, timeout_o}, '0);
                check("no_cpl_data", req0_data_o | req1_data_o, '0);
            end
        end
    end

    initial begin
        do_reset();

        // Port 1 read answered on the 3rd BUSY cycle
        issue(1, 32'h100, 32'h0, 1, 0);
        force_lat = 3; use_force_data = 1; force_data = 32'hDEADBEEF;
        drain();

        // Fresh tie after reset, then both held continuously: grants alternate
        do_reset();
        for (int i = 0; i < 24; i++) begin
            for (int p = 0; p < 2; p++)
                if (!p_pend[p] && !p_cool[p]) issue(p, 32'h2000 + 32'(p) * 16 + 32'(i), $urandom, 1, 0);
            step();
        end
        drain();

        // Read and write together is a write
        step();
        issue(0, 32'h40, 32'h12345678, 1, 1);
        drain();

        // Memory never answers: abort on the 4th BUSY cycle, then a normal grant
        issue(0, 32'h80, 32'h0, 1, 0);
        force_lat = 99;
        drain();
        issue(0, 32'h84, 32'h0, 1, 0);
        force_lat = 2;
        drain();

        // Answer coincides with the watchdog limit
        issue(1, 32'h88, 32'h0, 1, 0);
        force_lat = 4;
        drain();

        // Reset mid-transaction, then the first tie goes to port 0
        issue(1, 32'h90, 32'h0, 0, 1);
        force_lat = 99;
        step(); step(); step();
        #2 do_reset();
        issue(0, 32'hA0, 32'h1, 1, 0);
        issue(1, 32'hB0, 32'h2, 1, 0);
        drain();

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            for (int p = 0; p < 2; p++)
                if (!p_pend[p] && !p_cool[p] && $urandom_range(2) == 0) issue_rand(p);
            step();
        end
        drain();
        step();
        @(negedge clk); #1;
        check("queues_empty", 32'(g_q.size() + c_q.size()), '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-ported memory interface between the core's two memory requesters: port 0 (MEM stage, data load/store) and port 1 (IF stage, instruction fetch). It sits between `core_top` and memory, which reduces the core's two-lane memory bus to one physical port. Grants are round-robin, and each granted request is latched and held on the downstream port until memory answers. An optional watchdog terminates transactions that memory never answers.

## Interface
Parameters:
- BITSIZE, 32, width of address and data
- TIMEOUT, 0, cycles the downstream port may stay busy before the watchdog aborts; 0 disables the watchdog

Ports:
- clk  in  1  single clock, rising edge
- resetn_i  in  1  asynchronous, active-low reset
- req0_addr_i  in  BITSIZE  port 0 (MEM stage) address
- req0_data_i  in  BITSIZE  port 0 write data
- req0_read_i  in  1  port 0 read request, level
- req0_write_i  in  1  port 0 write request, level
- req0_data_o  out  BITSIZE  port 0 read data
- req0_valid_o  out  1  port 0 completion pulse
- req1_addr_i, req1_data_i, req1_read_i, req1_write_i, req1_data_o, req1_valid_o  same as port 0, for port 1 (IF stage)
- mem_addr_o  out  BITSIZE  downstream address, registered
- mem_data_o  out  BITSIZE  downstream write data, registered
- mem_read_o  out  1  downstream read strobe, registered
- mem_write_o  out  1  downstream write strobe, registered
- mem_data_i  in  BITSIZE  downstream read data
- mem_valid_i  in  1  downstream completion, one-cycle pulse
- busy_o  out  1  high while a transaction is outstanding
- timeout_o  out  1  one-cycle pulse when the watchdog aborts a transaction

## Operation
States: IDLE and BUSY. Internal registers: `gnt` (port currently granted), `last` (port granted most recently) and a watchdog counter.

Request rules:
- A port is requesting when its read or write input is high.
- If both read and write are high on one port, the request is a write; `mem_read_o` stays 0.

IDLE:
- If exactly one port is requesting, grant it.
- If both ports are requesting, grant the port that is not `last`.
- On a grant, latch that port's address, write data and strobe into the mem_* output registers; set `gnt` and `last`; go to BUSY.
- With no request, stay in IDLE with all strobes at 0.
- `mem_valid_i` is ignored in IDLE.

BUSY:
- Hold `mem_addr_o`, `mem_data_o` and the strobes constant.
- Requester inputs are ignored, so a requester dropping or changing its request mid-transaction has no effect.
- When `mem_valid_i` is high:
  - assert the granted port's `valid_o` in the same cycle (combinational);
  - drive that port's `data_o` with `mem_data_i`;
  - at the next edge clear the strobes, clear the counter and go to IDLE.
- The ungranted port's `valid_o` is always 0.

Read data outputs:
- `reqN_data_o` equals `mem_data_i` when `reqN_valid_o` is high.
- Otherwise `reqN_data_o` is 0.

Requester obligation: a requester deasserts its request in the cycle after its `valid_o`. A request still high in IDLE is treated as a new request.

Watchdog (TIMEOUT>0):
- The counter increments on every BUSY cycle in which `mem_valid_i` is 0.
- When the counter reaches TIMEOUT, the abort happens in that same cycle:
  - pulse `timeout_o`;
  - pulse the granted port's `valid_o` with `data_o` = 0 (the pipeline is not left hung);
  - go to IDLE.
- If `mem_valid_i` arrives in the same cycle the counter reaches TIMEOUT, the transaction completes normally and there is no timeout.

Reset (asynchronous, applies at any time including mid-transaction):
- State = IDLE, `gnt` = 0, `last` = 1 (port 0 wins the first tie), counter = 0.
- All outputs are 0: every mem_* output, every `req*_valid_o`, every `req*_data_o`, `busy_o` and `timeout_o`.
- No completion is signalled for a transaction aborted by reset.

## Timing
- Cycle 0: IDLE, request sampled. Cycle 1: mem strobe, address and data driven from registers; `busy_o` = 1.
- `valid_o` appears in the same cycle as `mem_valid_i`.
- Minimum transaction is 2 cycles (memory answers in cycle 1); add 1 IDLE cycle before the next grant, for a 3-cycle request-to-request period.
- `busy_o` = 1 exactly in BUSY.
- `timeout_o` and `valid_o` are never asserted outside BUSY.

## Test plan
- Port 1 read, addr 0x100; memory returns 0xDEADBEEF 2 cycles after the strobe -> `mem_read_o` high cycles 1–3, `req1_valid_o` with 0xDEADBEEF in cycle 3, `req0_valid_o` stays 0.
- Ports 0 and 1 request together from reset -> port 0 granted first; port 1 granted in the IDLE after port 0 completes; with both held continuously, grants alternate 0,1,0,1.
- Port 0 with read and write both high, data 0x12345678 -> `mem_write_o` = 1, `mem_read_o` = 0, `mem_data_o` = 0x12345678.
- TIMEOUT=4, memory never answers -> `timeout_o` and `req0_valid_o` pulse on the 4th BUSY cycle with data 0; next request granted normally.
- TIMEOUT=4, `mem_valid_i` arrives on the 4th BUSY cycle -> normal completion with memory data, no `timeout_o`.
- `resetn_i` low mid-BUSY -> all outputs 0 immediately; after release, the first tie goes to port 0.
